instruction_fetch: RTL and testbench

Fetch-side initiator for the synchronous instruction memory. Holds the program counter, drives the memory word address, waits the memory read latency, and captures the returned 32-bit word. Presents the word to decode with a valid/ready handshake. Accepts start (program select) and redirect (branch/jump resolved downstream), and flags fetches beyond the populated memory depth.

---
 rtl/instruction_fetch.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch-side initiator for the synchronous instruction memory.
// Holds the PC, drives the memory word address, waits MEM_LATENCY edges,
// captures the returned word and offers it to decode.
//
// Handshake: instr_valid/instr_ready. An instruction is transferred at a rising
// edge where instr_valid & instr_ready are both high. instr and instr_pc stay
// stable while instr_valid is high and the word has not yet been transferred.
//
// Optional build macro: FETCH_JUMP_FOLD_EN. When it is defined, a jump word
// (opcode 6'b010000) is folded at capture. The word is never shown to decode,
// and the PC is reloaded from its low ADDR_W bits.
module instruction_fetch #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 81,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_instr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // One extra bit so that a depth equal to 2^ADDR_W can still be represented.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [1:0]      LAT_L   = 2'(MEM_LATENCY);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [1:0]        cnt, cnt_next;
    logic [DATA_W-1:0] instr_q, instr_next;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_next;
    logic              valid_q, valid_next;
    logic              fault_q, fault_next;
    logic              out_of_range;
    logic              fold_jump;

    assign out_of_range = ({1'b0, pc} >= DEPTH_L);

`ifdef FETCH_JUMP_FOLD_EN
    assign fold_jump = (mem_instr[31:26] == 6'b010000);
`else
    assign fold_jump = 1'b0;
`endif

    // State and datapath registers. Every register clears on asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= '0;
            cnt        <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            cnt        <= cnt_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_next;
            valid_q    <= valid_next;
            fault_q    <= fault_next;
        end
    end

    // Next-state logic. Outside IDLE the priority is stop, then redirect,
    // then the normal per-state action.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        cnt_next      = cnt;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;
        valid_next    = valid_q;
        fault_next    = fault_q;

        if (state == IDLE) begin
            valid_next = 1'b0;
            if (start) begin
                pc_next    = start_addr;
                fault_next = 1'b0;
                state_next = ISSUE;
            end
        end else if (stop) begin
            valid_next = 1'b0;
            state_next = IDLE;
        end else if (redirect) begin
            // Abandon any read in flight; the word it returns is never captured.
            pc_next    = redirect_addr;
            valid_next = 1'b0;
            cnt_next   = '0;
            state_next = ISSUE;
        end else begin
            case (state)
                ISSUE: begin
                    if (out_of_range) begin
                        fault_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = LAT_L;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd1) begin
                        if (fold_jump) begin
                            pc_next    = mem_instr[ADDR_W-1:0];
                            cnt_next   = '0;
                            state_next = ISSUE;
                        end else begin
                            instr_next    = mem_instr;
                            instr_pc_next = pc;
                            valid_next    = 1'b1;
                            state_next    = HOLD;
                        end
                    end else begin
                        cnt_next = cnt - 2'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_next = 1'b0;
                        pc_next    = pc + 1'b1;
                        state_next = ISSUE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign mem_address = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign busy        = (state != IDLE);
    assign debug_state = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. The memory model has one cycle of
// latency and returns 32'hA000_0000 + addr. The one exception is address 9,
// which holds the jump word 32'h4000_0006.
module tb_instruction_fetch;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stop;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_instr;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              busy;
    logic              fault;
    logic [1:0]        debug_state;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] exp_q[$];

    // Clock
    always #5 clock = ~clock;

    instruction_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(81), .MEM_LATENCY(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .stop(stop), .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_address(mem_address), .mem_instr(mem_instr), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .fault(fault), .debug_state(debug_state)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 10'd9) return 32'h4000_0006;
        return 32'hA000_0000 + {22'b0, a};
    endfunction

    // Synchronous memory: the address is sampled at an edge, and the data is usable from the next edge.
    always @(posedge clock) mem_instr <= mem_word(mem_address);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Step on falling edges until instr_valid is seen or the budget runs out.
    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!instr_valid && cycles < max);
        check("valid_seen", instr_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [ADDR_W-1:0] e;
        reset_n = 1'b0; start = 0; start_addr = '0; stop = 0;
        redirect = 0; redirect_addr = '0; instr_ready = 0;

        // reset state
        #2;
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_addr", mem_address, 0);
        check("rst_instr", instr, 0);
        check("rst_state", debug_state, 0);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);

        // start at 0 with ready high: valid after edge 2, then one word every 3 cycles
        start = 1; start_addr = 0; instr_ready = 1;
        @(negedge clock); start = 0;
        check("issue_busy", busy, 1);
        check("issue_addr", mem_address, 0);
        check("issue_valid", instr_valid, 0);
        wait_valid(10, cyc);
        check("first_latency", cyc, 2);
        check("first_instr", instr, 32'hA000_0000);
        check("first_pc", instr_pc, 0);
        for (int i = 1; i <= 3; i++) begin
            wait_valid(10, cyc);
            check("throughput", cyc, 3);
            check("seq_pc", instr_pc, i);
            check("seq_instr", instr, 32'hA000_0000 + i);
        end

        // pc3 is accepted on this edge; ready is held low for pc4
        @(negedge clock); instr_ready = 0;
        check("issue4_addr", mem_address, 4);
        wait_valid(10, cyc);
        check("pc4", instr_pc, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_valid", instr_valid, 1);
            check("hold_pc", instr_pc, 4);
            check("hold_instr", instr, 32'hA000_0004);
            check("hold_addr", mem_address, 4);
        end
        instr_ready = 1;
        @(negedge clock);
        check("accept_valid", instr_valid, 0);
        check("issue5_addr", mem_address, 5);
        wait_valid(10, cyc);
        check("pc5", instr_pc, 5);
        wait_valid(10, cyc);
        check("pc6", instr_pc, 6);

        // redirect wins over ready in HOLD
        redirect = 1; redirect_addr = 15;
        @(negedge clock); redirect = 0;
        check("redir_valid", instr_valid, 0);
        check("redir_addr", mem_address, 15);
        wait_valid(10, cyc);
        check("redir_latency", cyc, 2);
        check("redir_pc", instr_pc, 15);
        check("redir_instr", instr, 32'hA000_000F);

        // stop returns to IDLE and keeps the pc
        stop = 1;
        @(negedge clock); stop = 0;
        check("stop_busy", busy, 0);
        check("stop_valid", instr_valid, 0);
        check("stop_addr", mem_address, 15);
        // redirect is ignored in IDLE
        redirect = 1; redirect_addr = 3;
        @(negedge clock); redirect = 0;
        check("idle_redir_busy", busy, 0);
        check("idle_redir_addr", mem_address, 15);

        // last valid word, then a fault on the issue past the end
        start = 1; start_addr = 80;
        @(negedge clock); start = 0;
        wait_valid(10, cyc);
        check("pc80", instr_pc, 80);
        check("instr80", instr, 32'hA000_0050);
        @(negedge clock);
        check("issue81_addr", mem_address, 81);
        check("issue81_busy", busy, 1);
        check("issue81_fault", fault, 0);
        @(negedge clock);
        check("fault_set", fault, 1);
        check("fault_busy", busy, 0);
        check("fault_valid", instr_valid, 0);

        // a new start clears the fault; then reset is asserted in the middle of HOLD
        instr_ready = 0; start = 1; start_addr = 7;
        @(negedge clock); start = 0;
        check("fault_clr", fault, 0);
        check("restart_busy", busy, 1);
        wait_valid(10, cyc);
        check("pc7", instr_pc, 7);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", mem_address, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_instr", instr, 0);
        check("arst_state", debug_state, 0);
        @(negedge clock); reset_n = 1'b1;

        // the jump at 9 is folded when the feature is on, and presented when it is off
        exp_q.push_back(10'd7);
        exp_q.push_back(10'd8);
`ifdef FETCH_JUMP_FOLD_EN
        exp_q.push_back(10'd6);
`else
        exp_q.push_back(10'd9);
`endif
        instr_ready = 1; start = 1; start_addr = 7;
        @(negedge clock); start = 0;
        while (exp_q.size() > 0) begin
            wait_valid(20, cyc);
            e = exp_q.pop_front();
            check("jump_seq_pc", instr_pc, e);
            check("jump_seq_instr", instr, mem_word(e));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
